// File: rtl/io_pattern_pkg.sv
// Shared constants for the mprj_io[7:0] pattern generator: sequence length,
// the pattern table and the controller state encoding.
package io_pattern_pkg;

  localparam int SEQ_LEN = 12;

  // Entry 0 sits in the least-significant byte.
  localparam logic [SEQ_LEN-1:0][7:0] PATTERN = {
    8'h00, 8'hFF, 8'h0A, 8'h09, 8'h08, 8'h07,
    8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  function automatic logic [7:0] pattern_at(input logic [3:0] idx);
    logic [7:0] val;
    val = 8'h00;
    if (int'(idx) < SEQ_LEN) val = PATTERN[idx];
    return val;
  endfunction

endpackage

// File: rtl/io_pattern_gen_if.sv
// Control/status bundle of the pattern generator; master drives requests,
// slave (the generator) drives the pad pattern and status.
interface io_pattern_gen_if #(parameter int HOLD_W = 16);
  logic              start;
  logic              abort;
  logic [HOLD_W-1:0] hold_cycles;
  logic [7:0]        io_out;
  logic [7:0]        io_oeb;
  logic              busy;
  logic              done;
  logic [3:0]        step_idx;

  modport master (
    output start, abort, hold_cycles,
    input  io_out, io_oeb, busy, done, step_idx
  );

  modport slave (
    input  start, abort, hold_cycles,
    output io_out, io_oeb, busy, done, step_idx
  );
endinterface

// File: rtl/io_pattern_gen.sv
// Steps mprj_io[7:0] through a fixed 12-entry pattern, holding each value a
// programmable number of cycles, then pulses done for one cycle.
module io_pattern_gen
  import io_pattern_pkg::*;
#(
  parameter int HOLD_W = 16
) (
  input  logic             clock,
  input  logic             resetb,
  io_pattern_gen_if.slave  bus
);

  localparam logic [HOLD_W-1:0] ONE  = HOLD_W'(1);
  localparam logic [3:0]        LAST = 4'(SEQ_LEN - 1);

  state_t            state;
  logic [HOLD_W-1:0] hold_len;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_start;
  logic [7:0]        io_out;
  logic [7:0]        io_oeb;
  logic              busy;
  logic              done;
  logic [3:0]        step_idx;

  // A zero hold request behaves like one cycle per entry.
  assign hold_start = (bus.hold_cycles == '0) ? ONE : bus.hold_cycles;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state    <= IDLE;
      hold_len <= ONE;
      hold_cnt <= '0;
      io_out   <= 8'h00;
      io_oeb   <= 8'hFF;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_idx <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state    <= RUN;
            hold_len <= hold_start;
            hold_cnt <= hold_start - ONE;
            io_out   <= pattern_at(4'd0);
            io_oeb   <= 8'h00;
            busy     <= 1'b1;
            step_idx <= 4'd0;
          end
        end

        RUN: begin
          if (bus.abort) begin
            state    <= IDLE;
            hold_cnt <= '0;
            io_out   <= 8'h00;
            io_oeb   <= 8'hFF;
            busy     <= 1'b0;
            step_idx <= 4'd0;
          end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - ONE;
          end else if (step_idx == LAST) begin
            // Pads stay driven low through the done cycle.
            state  <= FINISH;
            io_out <= 8'h00;
            io_oeb <= 8'h00;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            step_idx <= step_idx + 4'd1;
            io_out   <= pattern_at(step_idx + 4'd1);
            hold_cnt <= hold_len - ONE;
          end
        end

        FINISH: begin
          state    <= IDLE;
          hold_cnt <= '0;
          io_out   <= 8'h00;
          io_oeb   <= 8'hFF;
          busy     <= 1'b0;
          done     <= 1'b0;
          step_idx <= 4'd0;
        end

        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
          io_out   <= 8'h00;
          io_oeb   <= 8'hFF;
          busy     <= 1'b0;
          done     <= 1'b0;
          step_idx <= 4'd0;
        end
      endcase
    end
  end

  assign bus.io_out   = io_out;
  assign bus.io_oeb   = io_oeb;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.step_idx = step_idx;

endmodule

// File: doc/io_pattern_gen.md
IO_PATTERN_GEN -- requirements
Module: io_pattern_gen

Interface
REQ-001 Parameter HOLD_W, default 16, SHALL set the width of the hold-period input and the hold counter.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 resetb  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-004 start  input  1  SHALL request one run of the pattern; sampled only in IDLE.
REQ-005 abort  input  1  SHALL terminate a run in progress.
REQ-006 hold_cycles  input  HOLD_W  SHALL give the cycles each pattern value is held; sampled on accepted start.
REQ-007 io_out  output  8  SHALL be the pattern value for mprj_io[7:0].
REQ-008 io_oeb  output  8  SHALL be the per-bit output-enable bar (0 = driven).
REQ-009 busy  output  1  SHALL be high while a run is in progress.
REQ-010 done  output  1  SHALL pulse high for one cycle on normal completion.
REQ-011 step_idx  output  4  SHALL give the index (0..11) of the value currently driven.

Function
REQ-012 Pattern SHALL be 12 entries, index 0..11: 0x01..0x0A, 0xFF, 0x00.
REQ-013 FSM states SHALL be IDLE, RUN, FINISH.
REQ-014 IDLE: io_out=0x00, io_oeb=0xFF, busy=0, done=0, step_idx=0.
REQ-015 Accepted start (IDLE, start=1, abort=0) at edge N SHALL give RUN from cycle N+1: io_out=0x01, io_oeb=0x00, busy=1, step_idx=0.
REQ-016 Effective hold H SHALL be hold_cycles latched at start, with 0 treated as 1; each entry SHALL be held exactly H cycles.
REQ-017 After entry i has been held H cycles, entry i+1 SHALL appear the next cycle; step_idx SHALL track it.
REQ-018 After entry 11 (0x00) has been held H cycles, FSM SHALL enter FINISH for exactly one cycle: done=1, busy=0, io_out=0x00, io_oeb=0x00; next cycle IDLE.
REQ-019 start during RUN or FINISH SHALL be ignored; hold_cycles changes mid-run SHALL have no effect.
REQ-020 abort in RUN SHALL give IDLE next cycle with IDLE outputs and no done pulse.
REQ-021 abort and start both high in IDLE SHALL leave FSM in IDLE; abort wins.
REQ-022 abort in FINISH SHALL be ignored; done still pulses.
REQ-023 Run latency, start edge to done pulse, SHALL be 12*H+1 cycles.
REQ-024 Hold counter SHALL count down from H-1 and SHALL not wrap; H = 2^HOLD_W-1 SHALL be supported.

Reset
REQ-025 resetb low SHALL asynchronously force IDLE, io_out=0x00, io_oeb=0xFF, busy=0, done=0, step_idx=0, hold counter 0.
REQ-026 Reset mid-run SHALL abandon the run with no done pulse; the first start after release SHALL begin at entry 0.
REQ-027 Reset deassertion SHALL take effect on a clock edge; no output glitch on release.

Structure
REQ-028 Package io_pattern_pkg SHALL hold SEQ_LEN=12, the 12-entry pattern table and the FSM state enum.
REQ-029 The block SHALL be a single module with no sub-modules; the pattern is a package constant indexed by step_idx.

Verification
REQ-030 hold_cycles=1, start pulse -> io_out 01,02,...,0A,FF,00 on consecutive cycles; done on cycle 13 after start.
REQ-031 hold_cycles=3 -> each value held 3 cycles; done exactly 37 cycles after start edge.
REQ-032 hold_cycles=0 -> timing identical to hold_cycles=1.
REQ-033 start re-pulsed at step_idx=4, hold_cycles changed to 9 mid-run -> sequence and timing unchanged; single done.
REQ-034 abort while io_out=0x06 -> next cycle io_out=0x00, io_oeb=0xFF, busy=0; done never asserts.
REQ-035 resetb low while io_out=0x0A -> outputs immediately at reset values; after release, start -> full sequence from 0x01.
